alignment_result_collector: RTL and testbench

//  Downstream of the alignment top. Captures traceback letter pairs (emitted max-cell-first, i.e. reversed) plus the

---
 rtl/alignment_result_collector_pkg.sv | 31 +++
 rtl/alignment_result_collector_stack.sv | 52 +++++
 rtl/alignment_result_collector.sv | 154 +++++++++++++++
 tb/tb_alignment_result_collector.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alignment_result_collector_pkg.sv
// Shared constants, FSM state type and letter-code to ASCII mapping for the alignment result collector.
package design_variables;

    localparam logic [7:0] ASCII_A   = 8'h41;
    localparam logic [7:0] ASCII_C   = 8'h43;
    localparam logic [7:0] ASCII_G   = 8'h47;
    localparam logic [7:0] ASCII_T   = 8'h54;
    localparam logic [7:0] ASCII_GAP = 8'h2D;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        EMIT    = 2'd2,
        DONE    = 2'd3
    } collector_state_t;

    function automatic logic [7:0] letter_to_ascii(input logic gap, input logic [1:0] code);
        logic [7:0] r;
        r = ASCII_GAP;
        if (!gap) begin
            case (code)
                2'b00:   r = ASCII_A;
                2'b01:   r = ASCII_C;
                2'b10:   r = ASCII_G;
                default: r = ASCII_T;
            endcase
        end
        return r;
    endfunction

endpackage

// File: rtl/alignment_result_collector_stack.sv
// Register-based LIFO holding traceback pairs; top is the most recently pushed entry.
module result_stack #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 6,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] top,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [CNT_W-1:0] sp;
    logic [IDX_W-1:0] top_idx;
    logic [IDX_W-1:0] wr_idx;
    logic             do_push;
    logic             do_pop;

    assign full    = (sp == CNT_W'(DEPTH));
    assign empty   = (sp == '0);
    assign count   = sp;
    assign do_pop  = pop && !empty;
    // A simultaneous push and pop replaces the top entry, so a full stack still accepts it.
    assign do_push = push && (!full || do_pop);
    assign top_idx = IDX_W'(sp - CNT_W'(1));
    assign wr_idx  = do_pop ? top_idx : IDX_W'(sp);
    assign top     = mem[top_idx];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_idx] <= push_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp <= '0;
        end else begin
            case ({do_push, do_pop})
                2'b10:   sp <= sp + CNT_W'(1);
                2'b01:   sp <= sp - CNT_W'(1);
                default: sp <= sp;
            endcase
        end
    end

endmodule

// File: rtl/alignment_result_collector.sv
// Buffers reversed traceback pairs and replays them forward as ASCII beats over valid/ready.
// Optional match/mismatch/gap counters are built when ALIGN_STATS_EN is defined.
module alignment_result_collector
    import design_variables::*;
#(
    parameter int LETTER_WIDTH  = 2,
    parameter int SCORE_WIDTH   = 8,
    parameter int MAX_ALIGN_LEN = 64,
    localparam int DEPTH_W = $clog2(MAX_ALIGN_LEN + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   pair_valid,
    input  logic [LETTER_WIDTH:0]  query_in,
    input  logic [LETTER_WIDTH:0]  database_in,
    input  logic                   trace_done,
    input  logic [SCORE_WIDTH-1:0] score_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [7:0]             out_query,
    output logic [7:0]             out_database,
    output logic                   out_last,
    output logic [SCORE_WIDTH-1:0] result_score,
    output logic                   result_done,
    output logic                   busy,
    output logic                   overflow,
    output logic                   proto_err
`ifdef ALIGN_STATS_EN
    ,
    output logic [DEPTH_W-1:0]     stat_match,
    output logic [DEPTH_W-1:0]     stat_mismatch,
    output logic [DEPTH_W-1:0]     stat_gap
`endif
);

    localparam int PW = LETTER_WIDTH + 1;
    localparam int EW = 2 * PW;

    collector_state_t   state, state_next;
    logic [EW-1:0]      in_pair;
    logic [EW-1:0]      stack_top;
    logic [DEPTH_W-1:0] count;
    logic [DEPTH_W-1:0] avail;
    logic               full, empty;
    logic               taking, accept_pair, fin, bypass, push, pop, advance;

    function automatic logic [15:0] encode_pair(input logic [EW-1:0] p);
        return {letter_to_ascii(p[EW-1], p[PW+1:PW]), letter_to_ascii(p[PW-1], p[1:0])};
    endfunction

    assign in_pair     = {query_in, database_in};
    assign taking      = (state == IDLE) || (state == COLLECT);
    assign accept_pair = taking && pair_valid && !full;
    assign fin         = taking && trace_done;
    // A pair arriving with trace_done is the alignment start, so it goes straight to the output register.
    assign bypass      = fin && accept_pair;
    assign push        = accept_pair && !trace_done;
    assign avail       = count + DEPTH_W'(accept_pair);
    assign advance     = (state == EMIT) && out_valid && out_ready && !out_last;
    assign pop         = (fin && !bypass && !empty) || advance;
    assign busy        = (state != IDLE);
    assign result_done = (state == DONE);

    result_stack #(
        .DEPTH (MAX_ALIGN_LEN),
        .WIDTH (EW)
    ) u_stack (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (in_pair),
        .pop       (pop),
        .top       (stack_top),
        .full      (full),
        .empty     (empty),
        .count     (count)
    );

    always_comb begin
        state_next = state;
        case (state)
            IDLE, COLLECT: begin
                if (fin)             state_next = (avail == '0) ? DONE : EMIT;
                else if (pair_valid) state_next = COLLECT;
            end
            EMIT:    if (out_valid && out_ready && out_last) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid    <= 1'b0;
            out_query    <= '0;
            out_database <= '0;
            out_last     <= 1'b0;
        end else if (fin && (avail != '0)) begin
            out_valid                 <= 1'b1;
            {out_query, out_database} <= encode_pair(bypass ? in_pair : stack_top);
            out_last                  <= bypass ? (count == '0) : (count == DEPTH_W'(1));
        end else if (advance) begin
            {out_query, out_database} <= encode_pair(stack_top);
            out_last                  <= (count == DEPTH_W'(1));
        end else if ((state == EMIT) && out_valid && out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_score <= '0;
            overflow     <= 1'b0;
            proto_err    <= 1'b0;
        end else begin
            if (fin)                           result_score <= score_in;
            if (taking && pair_valid && full)  overflow     <= 1'b1;
            if ((state == EMIT) && (pair_valid || trace_done)) proto_err <= 1'b1;
        end
    end

`ifdef ALIGN_STATS_EN
    logic is_gap, is_match, is_mismatch, start;

    assign is_gap      = query_in[LETTER_WIDTH] | database_in[LETTER_WIDTH];
    assign is_match    = !is_gap && (query_in[LETTER_WIDTH-1:0] == database_in[LETTER_WIDTH-1:0]);
    assign is_mismatch = !is_gap && !is_match;
    // Any activity in IDLE opens a new alignment, so counters restart there.
    assign start       = (state == IDLE) && (pair_valid || trace_done);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_match    <= '0;
            stat_mismatch <= '0;
            stat_gap      <= '0;
        end else if (start) begin
            stat_match    <= DEPTH_W'(accept_pair && is_match);
            stat_mismatch <= DEPTH_W'(accept_pair && is_mismatch);
            stat_gap      <= DEPTH_W'(accept_pair && is_gap);
        end else if (accept_pair) begin
            stat_match    <= stat_match    + DEPTH_W'(is_match);
            stat_mismatch <= stat_mismatch + DEPTH_W'(is_mismatch);
            stat_gap      <= stat_gap      + DEPTH_W'(is_gap);
        end
    end
`endif

endmodule

// File: tb/tb_alignment_result_collector.sv
// Directed bench for alignment_result_collector with a queue-based reference model checked every cycle.
module tb_alignment_result_collector;

    localparam int MAXL = 64;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pair_valid = 1'b0;
    logic [2:0] query_in = '0;
    logic [2:0] database_in = '0;
    logic       trace_done = 1'b0;
    logic [7:0] score_in = '0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] out_query, out_database;
    logic       out_last;
    logic [7:0] result_score;
    logic       result_done, busy, overflow, proto_err;
`ifdef ALIGN_STATS_EN
    logic [6:0] stat_match, stat_mismatch, stat_gap;
`endif

    int checks = 0;
    int errors = 0;

    alignment_result_collector dut (
        .clk          (clk),
        .rst          (rst),
        .pair_valid   (pair_valid),
        .query_in     (query_in),
        .database_in  (database_in),
        .trace_done   (trace_done),
        .score_in     (score_in),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_query    (out_query),
        .out_database (out_database),
        .out_last     (out_last),
        .result_score (result_score),
        .result_done  (result_done),
        .busy         (busy),
        .overflow     (overflow),
        .proto_err    (proto_err)
`ifdef ALIGN_STATS_EN
        ,
        .stat_match    (stat_match),
        .stat_mismatch (stat_mismatch),
        .stat_gap      (stat_gap)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] asc(input logic [2:0] e);
        if (e[2]) return 8'h2D;
        case (e[1:0])
            2'd0:    return 8'h41;
            2'd1:    return 8'h43;
            2'd2:    return 8'h47;
            default: return 8'h54;
        endcase
    endfunction

    // Reference model: pushed pairs, pending beats in forward order, and sticky status.
    logic [5:0]  mstk[$];
    logic [5:0]  exp_q[$];
    logic [16:0] got[$];
    bit          in_emit = 0, done_due = 0, movf = 0, mperr = 0;
    logic [7:0]  mscore = '0;

    always @(negedge clk) begin
        bit done_next;
        if (rst) begin
            mstk.delete(); exp_q.delete();
            in_emit = 0; done_due = 0; movf = 0; mperr = 0; mscore = '0;
        end else begin
            chk("out_valid", 32'(out_valid), 32'(in_emit));
            if (in_emit && out_valid) begin
                chk("out_query", 32'(out_query), 32'(asc(exp_q[0][5:3])));
                chk("out_database", 32'(out_database), 32'(asc(exp_q[0][2:0])));
                chk("out_last", 32'(out_last), 32'(exp_q.size() == 1));
            end
            chk("result_done", 32'(result_done), 32'(done_due));
            chk("busy", 32'(busy), 32'(in_emit || done_due || mstk.size() > 0));
            chk("overflow", 32'(overflow), 32'(movf));
            chk("proto_err", 32'(proto_err), 32'(mperr));
            chk("result_score", 32'(result_score), 32'(mscore));
            if (out_valid && out_ready) got.push_back({out_query, out_database, out_last});
            done_next = 0;
            if (in_emit) begin
                if (pair_valid || trace_done) mperr = 1;
                if (out_ready) begin
                    void'(exp_q.pop_front());
                    if (exp_q.size() == 0) begin in_emit = 0; done_next = 1; end
                end
            end else if (!done_due) begin
                if (pair_valid) begin
                    if (mstk.size() == MAXL) movf = 1;
                    else mstk.push_back({query_in, database_in});
                end
                if (trace_done) begin
                    mscore = score_in;
                    if (mstk.size() == 0) done_next = 1;
                    else begin
                        for (int i = mstk.size() - 1; i >= 0; i--) exp_q.push_back(mstk[i]);
                        mstk.delete();
                        in_emit = 1;
                    end
                end
            end
            done_due = done_next;
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic send(input logic [2:0] q, input logic [2:0] d, input logic td, input logic [7:0] sc);
        pair_valid = 1'b1; query_in = q; database_in = d; trace_done = td; score_in = sc;
        step();
        pair_valid = 1'b0; trace_done = 1'b0;
    endtask

    task automatic run_until_done(input int budget, input bit toggle);
        int n = 0;
        while (!result_done && n < budget) begin
            if (toggle) out_ready = ~out_ready;
            step();
            n++;
        end
        out_ready = 1'b1;
        chk("done_within_budget", 32'(n < budget), 32'd1);
        step();
    endtask

    task automatic check_three(input string tag);
        logic [16:0] e0, e1, e2;
        e0 = {8'h47, 8'h47, 1'b0};
        e1 = {8'h43, 8'h2D, 1'b0};
        e2 = {8'h41, 8'h41, 1'b1};
        chk({tag, "_beats"}, 32'(got.size()), 32'd3);
        if (got.size() == 3) begin
            chk({tag, "_beat0"}, 32'(got[0]), 32'(e0));
            chk({tag, "_beat1"}, 32'(got[1]), 32'(e1));
            chk({tag, "_beat2"}, 32'(got[2]), 32'(e2));
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        step();
    endtask

    initial begin
        #3;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_result_done", 32'(result_done), 32'd0);
        chk("rst_flags", 32'({overflow, proto_err, out_last}), 32'd0);
        chk("rst_data", 32'({out_query, out_database, result_score}), 32'd0);
        do_reset();

        // Three pairs, trace_done with the last pair, host always ready.
        got.delete();
        send(3'b000, 3'b000, 1'b0, 8'd0);
        send(3'b001, 3'b100, 1'b0, 8'd0);
        send(3'b010, 3'b010, 1'b1, 8'd7);
        chk("valid_after_trace_done", 32'(out_valid), 32'd1);
        run_until_done(20, 1'b0);
        check_three("ready");
        chk("score7", 32'(result_score), 32'd7);
        chk("idle_after_done", 32'(busy), 32'd0);

        // Same pairs, separate trace_done, host toggling ready.
        got.delete();
        send(3'b000, 3'b000, 1'b0, 8'd0);
        send(3'b001, 3'b100, 1'b0, 8'd0);
        send(3'b010, 3'b010, 1'b0, 8'd0);
        trace_done = 1'b1; score_in = 8'd7; step(); trace_done = 1'b0;
        run_until_done(40, 1'b1);
        check_three("stall");

        // Empty alignment.
        trace_done = 1'b1; score_in = 8'd5; step(); trace_done = 1'b0;
        chk("empty_done_pulse", 32'(result_done), 32'd1);
        chk("empty_no_valid", 32'(out_valid), 32'd0);
        step();
        chk("empty_done_clear", 32'(result_done), 32'd0);
        chk("empty_idle", 32'(busy), 32'd0);
        chk("empty_score", 32'(result_score), 32'd5);

        // 65 pairs into a 64-deep stack.
        got.delete();
        for (int i = 0; i < 65; i++) begin
            logic [5:0] p;
            p = 6'(i) ^ 6'b100100;
            send(p[5:3], p[2:0], i == 64, 8'd9);
        end
        run_until_done(200, 1'b0);
        chk("ovf_flag", 32'(overflow), 32'd1);
        chk("ovf_beats", 32'(got.size()), 32'd64);
        if (got.size() == 64) begin
            chk("ovf_first", 32'(got[0]), 32'({8'h54, 8'h54, 1'b0}));
            chk("ovf_last", 32'(got[63]), 32'({8'h2D, 8'h2D, 1'b1}));
        end
        do_reset();
        chk("ovf_cleared", 32'(overflow), 32'd0);

        // Pair and trace_done during EMIT while the host stalls.
        got.delete();
        send(3'b000, 3'b000, 1'b0, 8'd0);
        send(3'b001, 3'b100, 1'b0, 8'd0);
        send(3'b010, 3'b010, 1'b1, 8'd7);
        out_ready = 1'b0;
        step();
        send(3'b011, 3'b011, 1'b1, 8'd99);
        out_ready = 1'b1;
        run_until_done(20, 1'b0);
        chk("proto_err_set", 32'(proto_err), 32'd1);
        check_three("proto");

        // Reset in the middle of EMIT, then a one-pair alignment.
        send(3'b000, 3'b001, 1'b0, 8'd0);
        send(3'b010, 3'b011, 1'b0, 8'd0);
        send(3'b011, 3'b000, 1'b1, 8'd3);
        out_ready = 1'b0;
        step();
        rst = 1'b1;
        #1;
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_proto", 32'(proto_err), 32'd0);
        step(); step();
        rst = 1'b0;
        out_ready = 1'b1;
        step();
        got.delete();
        send(3'b000, 3'b001, 1'b1, 8'd4);
        run_until_done(20, 1'b0);
        chk("post_rst_beats", 32'(got.size()), 32'd1);
        if (got.size() == 1) chk("post_rst_beat", 32'(got[0]), 32'({8'h41, 8'h43, 1'b1}));

`ifdef ALIGN_STATS_EN
        send(3'b000, 3'b000, 1'b0, 8'd0);
        send(3'b001, 3'b010, 1'b0, 8'd0);
        send(3'b100, 3'b011, 1'b1, 8'd2);
        run_until_done(20, 1'b0);
        chk("stat_match", 32'(stat_match), 32'd1);
        chk("stat_mismatch", 32'(stat_mismatch), 32'd1);
        chk("stat_gap", 32'(stat_gap), 32'd1);
`endif

        step(); step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

endmodule
